key_command_fsm: RTL
====================

# key_command_fsm

Sequential command interpreter directly downstream of the key decoder. Consumes the one-cycle key-detect strobes plus the low nibble of the received character and turns them into control for the clock core. Controls produced: run/stop pulses, alarm enable, LED select, and a validated four-digit HH:MM entry committed as a load pulse to either the time-of-day or the alarm register.

## Interface
- TIMEOUT_CYC, 24'd12_000_000: idle cycles allowed during digit entry before abort (only with timeout macro).
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- det_esc, det_num, det_num0to5, det_cr, det_atSign, det_A, det_L, det_N, det_S  in  1 each  key strobes; each valid for one cycle, already gated by charDataValid.
- digit_val  in  4  charData[3:0]; meaningful only when det_num is high.
- entry_active  out  1  high while in ENTRY or WAIT_CR.
- entry_target  out  1  0 = time-of-day, 1 = alarm; latched on entry start.
- entry_digits  out  16  {hr_tens, hr_units, min_tens, min_units}, BCD, 4 bits each.
- digit_count  out  3  digits accepted so far, 0..4.
- load_tod  out  1  one-cycle commit pulse to the time-of-day register.
- load_alarm  out  1  one-cycle commit pulse to the alarm register.
- run_pulse  out  1  one-cycle start pulse.
- stop_pulse  out  1  one-cycle stop pulse.
- alarm_en  out  1  level; toggled by L.
- led_sel  out  2  level; LED select, incremented by N, wraps 3→0.
- key_err  out  1  one-cycle pulse on a rejected key.

## Operation
- States: IDLE, ENTRY, WAIT_CR.
- Reset values:
  - State is IDLE.
  - All pulses are 0.
  - entry_digits = 16'h0000, digit_count = 0, entry_target = 0.
  - alarm_en = 0, led_sel = 2'd0.
- Priority when several strobes coincide: esc > cr > digit > letters. det_num and det_num0to5 together count as one digit event.
- IDLE:
  - @ → ENTRY, entry_target = 0, digits cleared, digit_count = 0.
  - A → same as @, but entry_target = 1.
  - S → run_pulse.
  - CR → stop_pulse.
  - L → toggle alarm_en.
  - N → led_sel + 1, modulo 4.
  - Digits and esc are ignored; no error is flagged.
- ENTRY: a digit is accepted into the position given by digit_count only if it meets that position's limit:
  - pos0, hour tens: 0–2.
  - pos1, hour units: 0–9, or 0–3 when hr_tens = 2.
  - pos2, minute tens: 0–5 (det_num0to5 required).
  - pos3, minute units: 0–9.
  - Accepted digit: store it and increment digit_count. On the 4th accepted digit → WAIT_CR.
  - Rejected digit: key_err pulse; digits and digit_count unchanged.
  - Letters and @ in ENTRY: key_err, no other effect.
  - CR before the 4th digit: key_err, stay in ENTRY.
- WAIT_CR:
  - CR → load_tod or load_alarm (chosen by entry_target), then IDLE.
  - Digit or letter → key_err, no change.
- Esc in ENTRY or WAIT_CR → IDLE, digit_count = 0. entry_digits keeps its last value. No load.
- entry_digits is stable from the load pulse until the next entry start.

## Timing
- Every output is registered. Response appears in the cycle after the strobe cycle, i.e. 1-cycle latency.
- Pulses are exactly one cycle wide.
- Back-to-back strobes on consecutive cycles are all processed; no dead cycle is required.
- rst_n low at any clock edge restores the reset values on that edge, including mid-entry; no load pulse is issued.

## Configuration
- ENTRY_TIMEOUT_EN defined:
  - A counter is cleared at entry start and by every strobe while entry_active.
  - When it reaches TIMEOUT_CYC−1 → IDLE with the same effect as esc, plus one key_err pulse.
- ENTRY_TIMEOUT_EN undefined:
  - No counter is built and TIMEOUT_CYC is unused.
  - Entry waits indefinitely.

## Structure
- Shared package holds:
  - the state encoding (IDLE = 2'd0, ENTRY = 2'd1, WAIT_CR = 2'd2);
  - the digit-limit constants (HR_TENS_MAX = 2, HR_UNITS_MAX_AT_20 = 3, MIN_TENS_MAX = 5);
  - the target encoding (TGT_TOD = 0, TGT_ALARM = 1).
- One sub-module: digit_limit_check. It is combinational: digit_count, hr_tens, digit_val, det_num0to5 → accept.

## Test plan
- Sequence @,1,2,3,4,CR → entry_digits = 16'h1234, one load_tod pulse 1 cycle after CR, load_alarm stays 0, back in IDLE.
- A,2,4 → key_err and digit_count stays 1; then 3,5,9,CR → entry_digits = 16'h2359 and one load_alarm pulse.
- @,0,7 then 6 at pos2 → key_err; then esc → IDLE with no load pulse; then CR → stop_pulse, not a load.
- In IDLE, N pressed 5 times → led_sel sequence 1,2,3,0,1. L twice → alarm_en 1 then 0. S → one run_pulse.
- Mid-entry (after @,1) drive rst_n low for one edge → all outputs at reset values. A following CR produces stop_pulse only.
- With ENTRY_TIMEOUT_EN and TIMEOUT_CYC = 16: after @ and no keys → IDLE plus key_err at cycle 16. A key at cycle 10 restarts the count.

Source files
------------

// File: rtl/key_command_fsm_pkg.sv
// ============================================================================
// key_command_fsm_pkg : state, digit-limit and target encodings  | Rev 1.0
// ============================================================================
`default_nettype none

package key_command_fsm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ENTRY   = 2'd1,
    ST_WAIT_CR = 2'd2
  } state_t;

  localparam logic [3:0] HR_TENS_MAX        = 4'd2;
  localparam logic [3:0] HR_UNITS_MAX_AT_20 = 4'd3;
  localparam logic [3:0] MIN_TENS_MAX       = 4'd5;
  localparam logic [3:0] DEC_MAX            = 4'd9;

  localparam logic TGT_TOD   = 1'b0;
  localparam logic TGT_ALARM = 1'b1;

endpackage

`default_nettype wire

// File: rtl/key_command_fsm_digit_limit_check.sv
// ============================================================================
// digit_limit_check : accepts a BCD digit if it fits the HH:MM slot  | Rev 1.0
// ============================================================================
`default_nettype none

module digit_limit_check
  import key_command_fsm_pkg::*;
(
  input  logic [2:0] digit_count_i,
  input  logic [3:0] hr_tens_i,
  input  logic [3:0] digit_val_i,
  input  logic       det_num0to5_i,
  output logic       accept_o
);

  always_comb begin
    accept_o = 1'b0;
    case (digit_count_i)
      3'd0: accept_o = (digit_val_i <= HR_TENS_MAX);
      3'd1: accept_o = (hr_tens_i == HR_TENS_MAX) ? (digit_val_i <= HR_UNITS_MAX_AT_20)
                                                  : (digit_val_i <= DEC_MAX);
      // Minute tens relies on the decoder's 0-5 strobe, not just the nibble.
      3'd2: accept_o = det_num0to5_i && (digit_val_i <= MIN_TENS_MAX);
      3'd3: accept_o = (digit_val_i <= DEC_MAX);
      default: accept_o = 1'b0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/key_command_fsm.sv
// ============================================================================
// key_command_fsm : key strobes -> clock-core control and HH:MM loads | Rev 1.0
// Optional entry timeout: define ENTRY_TIMEOUT_EN.
// ============================================================================
`default_nettype none

module key_command_fsm
  import key_command_fsm_pkg::*;
#(
  parameter logic [23:0] TIMEOUT_CYC = 24'd12_000_000
)
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        det_esc,
  input  logic        det_num,
  input  logic        det_num0to5,
  input  logic        det_cr,
  input  logic        det_atSign,
  input  logic        det_A,
  input  logic        det_L,
  input  logic        det_N,
  input  logic        det_S,
  input  logic [3:0]  digit_val,
  output logic        entry_active,
  output logic        entry_target,
  output logic [15:0] entry_digits,
  output logic [2:0]  digit_count,
  output logic        load_tod,
  output logic        load_alarm,
  output logic        run_pulse,
  output logic        stop_pulse,
  output logic        alarm_en,
  output logic [1:0]  led_sel,
  output logic        key_err
);

  state_t      state_q;
  logic        entry_target_q;
  logic [15:0] entry_digits_q;
  logic [2:0]  digit_count_q;
  logic        load_tod_q;
  logic        load_alarm_q;
  logic        run_pulse_q;
  logic        stop_pulse_q;
  logic        alarm_en_q;
  logic [1:0]  led_sel_q;
  logic        key_err_q;

  logic w_digit;
  logic w_letter;
  logic w_any;
  logic w_accept;
  logic w_timeout;

  assign w_digit  = det_num | det_num0to5;
  assign w_letter = det_atSign | det_A | det_L | det_N | det_S;
  assign w_any    = w_digit | w_letter | det_esc | det_cr;

  digit_limit_check u_limit (
    .digit_count_i (digit_count_q),
    .hr_tens_i     (entry_digits_q[15:12]),
    .digit_val_i   (digit_val),
    .det_num0to5_i (det_num0to5),
    .accept_o      (w_accept)
  );

`ifdef ENTRY_TIMEOUT_EN
  logic [23:0] timer_q;

  // Held at zero in IDLE so it starts from zero on entry start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      timer_q <= '0;
    end else if (state_q == ST_IDLE || w_any || w_timeout) begin
      timer_q <= '0;
    end else begin
      timer_q <= timer_q + 24'd1;
    end
  end

  assign w_timeout = (state_q != ST_IDLE) && !w_any && (timer_q == TIMEOUT_CYC - 24'd1);
`else
  logic w_unused_timeout;
  assign w_unused_timeout = ^TIMEOUT_CYC;
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      entry_target_q <= TGT_TOD;
      entry_digits_q <= 16'h0000;
      digit_count_q  <= 3'd0;
      load_tod_q     <= 1'b0;
      load_alarm_q   <= 1'b0;
      run_pulse_q    <= 1'b0;
      stop_pulse_q   <= 1'b0;
      alarm_en_q     <= 1'b0;
      led_sel_q      <= 2'd0;
      key_err_q      <= 1'b0;
    end else begin
      load_tod_q   <= 1'b0;
      load_alarm_q <= 1'b0;
      run_pulse_q  <= 1'b0;
      stop_pulse_q <= 1'b0;
      key_err_q    <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (!det_esc) begin
            if (det_cr) begin
              stop_pulse_q <= 1'b1;
            end else if (!w_digit) begin
              if (det_atSign || det_A) begin
                state_q        <= ST_ENTRY;
                entry_target_q <= det_atSign ? TGT_TOD : TGT_ALARM;
                entry_digits_q <= 16'h0000;
                digit_count_q  <= 3'd0;
              end else if (det_S) begin
                run_pulse_q <= 1'b1;
              end else if (det_L) begin
                alarm_en_q <= ~alarm_en_q;
              end else if (det_N) begin
                led_sel_q <= led_sel_q + 2'd1;
              end
            end
          end
        end

        ST_ENTRY: begin
          if (w_timeout) begin
            state_q       <= ST_IDLE;
            digit_count_q <= 3'd0;
            key_err_q     <= 1'b1;
          end else if (det_esc) begin
            state_q       <= ST_IDLE;
            digit_count_q <= 3'd0;
          end else if (det_cr) begin
            key_err_q <= 1'b1;
          end else if (w_digit) begin
            if (w_accept) begin
              case (digit_count_q[1:0])
                2'd0:    entry_digits_q[15:12] <= digit_val;
                2'd1:    entry_digits_q[11:8]  <= digit_val;
                2'd2:    entry_digits_q[7:4]   <= digit_val;
                default: entry_digits_q[3:0]   <= digit_val;
              endcase
              digit_count_q <= digit_count_q + 3'd1;
              if (digit_count_q == 3'd3) begin
                state_q <= ST_WAIT_CR;
              end
            end else begin
              key_err_q <= 1'b1;
            end
          end else if (w_letter) begin
            key_err_q <= 1'b1;
          end
        end

        ST_WAIT_CR: begin
          if (w_timeout) begin
            state_q       <= ST_IDLE;
            digit_count_q <= 3'd0;
            key_err_q     <= 1'b1;
          end else if (det_esc) begin
            state_q       <= ST_IDLE;
            digit_count_q <= 3'd0;
          end else if (det_cr) begin
            state_q      <= ST_IDLE;
            load_tod_q   <= (entry_target_q == TGT_TOD);
            load_alarm_q <= (entry_target_q == TGT_ALARM);
          end else if (w_digit || w_letter) begin
            key_err_q <= 1'b1;
          end
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign entry_active = (state_q != ST_IDLE);
  assign entry_target = entry_target_q;
  assign entry_digits = entry_digits_q;
  assign digit_count  = digit_count_q;
  assign load_tod     = load_tod_q;
  assign load_alarm   = load_alarm_q;
  assign run_pulse    = run_pulse_q;
  assign stop_pulse   = stop_pulse_q;
  assign alarm_en     = alarm_en_q;
  assign led_sel      = led_sel_q;
  assign key_err      = key_err_q;

endmodule

`default_nettype wire
